// File: rtl/serial_word_assembler_pkg.sv
// Shared types and helpers for the serial word assembler and its output buffer.
package serial_word_assembler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int PARITY_MAX_W  = 64;

  // Even-parity bit for a word zero-extended to PARITY_MAX_W bits.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/word_out_buffer.sv
// Single-entry holding register for assembled words: valid/ready toward the
// consumer, and a sticky overrun flag for words that arrive while one is held.
module word_out_buffer
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_word,
  input  logic             in_ready,
  input  logic             in_clr_overrun,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             out_overrun
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;
  logic             drop;

  always_comb begin
    accept    = valid_q & in_ready;
    drop      = load_valid & valid_q & ~in_ready;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // A word accepted this cycle frees the slot for a word completing now.
    if (load_valid && !drop) begin
      word_d  = load_word;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (in_clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_word    = word_q;
  assign out_valid   = valid_q;
  assign out_overrun = overrun_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Collects an MSB-first serial bit stream into WIDTH-bit words and hands them to
// word_out_buffer. Define SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN for a trailing even-parity bit.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_bit_valid,
  input  logic             in_sync,
  input  logic             in_ready,
  input  logic             in_clr_overrun,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             out_overrun,
  output logic             out_parity_err
);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
  localparam int SHIFT_W = WIDTH;
`else
  localparam int SHIFT_W = WIDTH - 1;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic             done_valid;
  logic [WIDTH-1:0] done_word;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    done_valid = 1'b0;
    done_word  = {shift_q[WIDTH-2:0], in_bit};
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif

    // A sync restarts the frame; a bit arriving with it is the first of the new one.
    if (in_sync) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (in_bit_valid) begin
        shift_d = (shift_q << 1) | SHIFT_W'(in_bit);
        cnt_d   = CNT_W'(1);
        state_d = S_SHIFT;
      end
    end else if (in_bit_valid) begin
      unique case (state_q)
        S_IDLE: begin
          shift_d = (shift_q << 1) | SHIFT_W'(in_bit);
          cnt_d   = CNT_W'(1);
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          shift_d = (shift_q << 1) | SHIFT_W'(in_bit);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
            state_d = S_PARITY;
`else
            state_d    = S_IDLE;
            done_valid = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
        S_PARITY: begin
          state_d   = S_IDLE;
          done_word = shift_q;
          if (in_bit == even_parity(PARITY_MAX_W'(shift_q))) begin
            done_valid = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_CHECK_EN
  assign out_parity_err = parity_err_q;
`else
  assign out_parity_err = 1'b0;
`endif

  word_out_buffer #(
    .WIDTH(WIDTH)
  ) u_word_out_buffer (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_valid    (done_valid),
    .load_word     (done_word),
    .in_ready      (in_ready),
    .in_clr_overrun(in_clr_overrun),
    .out_word      (out_word),
    .out_valid     (out_valid),
    .out_overrun   (out_overrun)
  );

endmodule
